// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-image loader.
// The FSM states, the default header magic and the header length live here.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  localparam int          HDR_LEN   = 4;
  localparam logic [31:0] MAGIC_DEF = 32'h4153524D;

  // The header arrives MSB byte first, so index 0 selects bits 31:24.
  function automatic logic [7:0] magic_byte(input logic [31:0] magic,
                                            input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = magic[31:24];
      2'd1:    b = magic[23:16];
      2'd2:    b = magic[15:8];
      default: b = magic[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Writes a streamed "ASRM" program image into program RAM, zero-pads the
// remaining addresses and holds the CPU in reset until the image is complete.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 6,
  parameter int          WORD_SIZE  = 8,
  parameter logic [31:0] MAGIC      = MAGIC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_SIZE-1:0]  in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_SIZE-1:0]  wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH:0]     addr_q, addr_d;
  logic [1:0]              hdr_q, hdr_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_SIZE-1:0]    wr_data_q, wr_data_d;
  logic                    in_ready_q, cpu_hold_q, done_q, error_q;
  logic                    xfer;
  logic                    hdr_match;

  assign xfer      = in_valid & in_ready_q;
  assign hdr_match = (in_data == WORD_SIZE'(magic_byte(MAGIC, hdr_q)));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hdr_d     = hdr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HDR;
          addr_d  = '0;
          hdr_d   = '0;
        end
      end
      S_HDR: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q[ADDR_WIDTH-1:0];
          wr_data_d = in_data;
          addr_d    = addr_q + 1'b1;
          hdr_d     = hdr_q + 2'd1;
          // A last byte that completes a good header is a header-only image.
          if (!hdr_match)
            state_d = S_ERROR;
          else if (hdr_q == 2'(HDR_LEN - 1))
            state_d = in_last ? S_FILL : S_LOAD;
          else if (in_last)
            state_d = S_ERROR;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          if (addr_q[ADDR_WIDTH]) begin
            state_d = S_ERROR;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q[ADDR_WIDTH-1:0];
            wr_data_d = in_data;
            addr_d    = addr_q + 1'b1;
            if (in_last)
              state_d = (addr_q[ADDR_WIDTH-1:0] == TOP_ADDR) ? S_DONE : S_FILL;
          end
        end
      end
      S_FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q[ADDR_WIDTH-1:0];
        wr_data_d = '0;
        addr_d    = addr_q + 1'b1;
        if (addr_q[ADDR_WIDTH-1:0] == TOP_ADDR)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      hdr_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hdr_q      <= hdr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= (state_d == S_HDR) || (state_d == S_LOAD);
      cpu_hold_q <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      error_q    <= (state_d == S_ERROR);
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: streams images, mirrors RAM writes into a
// local array and compares against hand-computed images and flags.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, wr_en, cpu_hold, done, error;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [64];
  int         wr_cnt     = 0;
  int         contig_err = 0;
  int         load_id    = 0;
  int         seen_id    = 0;
  logic [6:0] exp_addr   = 7'd0;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM write mirror; a new load_id clears it before the next image.
  always @(negedge clk) begin
    if (load_id != seen_id) begin
      seen_id = load_id;
      for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
      wr_cnt     = 0;
      contig_err = 0;
      exp_addr   = 7'd0;
    end
    if (wr_en === 1'b1) begin
      if (7'(wr_addr) != exp_addr) contig_err++;
      mem[wr_addr] = wr_data;
      exp_addr     = 7'(wr_addr) + 7'd1;
      wr_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit new_load);
    step();
    if (new_load) load_id++;
    in_valid = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Presents one byte, waits for acceptance, returns just after the transfer edge.
  task automatic send(input logic [7:0] d, input logic last, input int gap);
    int n;
    repeat (gap) begin
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    step();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_img(input logic [7:0] img[$], input int maxgap);
    for (int i = 0; i < img.size(); i++)
      send(img[i], (i == img.size() - 1), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    step();
    while (!(done === 1'b1 || error === 1'b1) && n < 300) begin
      step();
      n++;
    end
    chk("end_timeout", 32'(n < 300), 32'd1);
  endtask

  task automatic check_ram(input string tag, input logic [7:0] img[$]);
    int         bad;
    logic [7:0] ev;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      ev = (i < img.size()) ? img[i] : 8'h00;
      if (mem[i] !== ev) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [7:0] img[$];
    int         cnt;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_error",    32'(error),    32'd0);
    reset = 1'b0;

    // Basic image 41 53 52 4D 16 3D
    pulse_start(1);
    chk("t1_hdr_ready", 32'(in_ready), 32'd1);
    send(8'h41, 1'b0, 0);
    chk("t1_lat_wr_en", 32'(wr_en),   32'd1);
    chk("t1_lat_addr",  32'(wr_addr), 32'd0);
    chk("t1_lat_data",  32'(wr_data), 32'h41);
    img = '{8'h53, 8'h52, 8'h4D, 8'h16, 8'h3D};
    send_img(img, 0);
    wait_end();
    img = '{8'h41, 8'h53, 8'h52, 8'h4D, 8'h16, 8'h3D};
    chk("t1_done",     32'(done),     32'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t1_error",    32'(error),    32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk("t1_wr_cnt",   32'(wr_cnt),   32'd64);
    chk("t1_contig",   32'(contig_err), 32'd0);
    chk("t1_byte5",    32'(mem[5]),   32'h3D);
    check_ram("t1_ram", img);

    // Bad header 41 53 52 4E, then recovery
    pulse_start(1);
    send(8'h41, 1'b0, 0);
    send(8'h53, 1'b0, 0);
    send(8'h52, 1'b0, 0);
    send(8'h4E, 1'b0, 0);
    chk("t2_wr_en",     32'(wr_en),    32'd1);
    chk("t2_wr_addr",   32'(wr_addr),  32'd3);
    chk("t2_wr_data",   32'(wr_data),  32'h4E);
    chk("t2_error",     32'(error),    32'd1);
    chk("t2_cpu_hold",  32'(cpu_hold), 32'd1);
    chk("t2_in_ready",  32'(in_ready), 32'd0);
    pulse_start(1);
    chk("t2_err_clear", 32'(error),    32'd0);
    img = '{8'h41, 8'h53, 8'h52, 8'h4D, 8'hAB};
    send_img(img, 0);
    wait_end();
    chk("t2_done",      32'(done),     32'd1);
    check_ram("t2_ram", img);

    // Overflow: 65 bytes without in_last
    pulse_start(1);
    img = '{8'h41, 8'h53, 8'h52, 8'h4D};
    for (int i = 4; i < 64; i++) img.push_back(8'(i));
    for (int i = 0; i < 64; i++) send(img[i], 1'b0, 0);
    step();
    chk("t3_cnt64",   32'(wr_cnt),   32'd64);
    chk("t3_ready64", 32'(in_ready), 32'd1);
    chk("t3_noerr64", 32'(error),    32'd0);
    send(8'h99, 1'b0, 0);
    chk("t3_no_write", 32'(wr_en), 32'd0);
    chk("t3_error",    32'(error), 32'd1);
    step();
    chk("t3_cnt_after", 32'(wr_cnt), 32'd64);
    chk("t3_addr0",     32'(mem[0]), 32'h41);
    check_ram("t3_ram", img);

    // Random gaps on in_valid
    pulse_start(1);
    img = '{8'h41, 8'h53, 8'h52, 8'h4D};
    for (int i = 0; i < 20; i++) img.push_back(8'($urandom_range(0, 255)));
    send_img(img, 3);
    wait_end();
    chk("t4_done",   32'(done),       32'd1);
    chk("t4_wr_cnt", 32'(wr_cnt),     32'd64);
    chk("t4_contig", 32'(contig_err), 32'd0);
    check_ram("t4_ram", img);

    // Reset during LOAD with address counter at 10
    pulse_start(1);
    img = '{8'h41, 8'h53, 8'h52, 8'h4D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 0; i < 10; i++) send(img[i], 1'b0, 0);
    step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_wr_en",    32'(wr_en),    32'd0);
    chk("t5_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t5_done",     32'(done),     32'd0);
    chk("t5_error",    32'(error),    32'd0);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    cnt = wr_cnt;
    repeat (5) step();
    in_valid = 1'b0;
    chk("t5_cnt10",    32'(cnt),      32'd10);
    chk("t5_no_write", 32'(wr_cnt),   32'd10);
    chk("t5_idle_rdy", 32'(in_ready), 32'd0);

    // start during FILL is ignored, then reload from DONE
    pulse_start(1);
    img = '{8'h41, 8'h53, 8'h52, 8'h4D, 8'hC3};
    send_img(img, 0);
    repeat (3) step();
    pulse_start(0);
    chk("t6_fill_ready", 32'(in_ready), 32'd0);
    chk("t6_fill_done",  32'(done),     32'd0);
    chk("t6_fill_hold",  32'(cpu_hold), 32'd1);
    wait_end();
    chk("t6_done",   32'(done),   32'd1);
    chk("t6_error",  32'(error),  32'd0);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd64);
    check_ram("t6_ram", img);
    pulse_start(1);
    chk("t6_re_hold",  32'(cpu_hold), 32'd1);
    chk("t6_re_done",  32'(done),     32'd0);
    chk("t6_re_ready", 32'(in_ready), 32'd1);

    // Header-only image: 60 zero-fill writes
    img = '{8'h41, 8'h53, 8'h52, 8'h4D};
    send_img(img, 0);
    wait_end();
    chk("t7_done",     32'(done),       32'd1);
    chk("t7_error",    32'(error),      32'd0);
    chk("t7_cpu_hold", 32'(cpu_hold),   32'd0);
    chk("t7_wr_cnt",   32'(wr_cnt),     32'd64);
    chk("t7_contig",   32'(contig_err), 32'd0);
    check_ram("t7_ram", img);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
